// File: rtl/i_cache_pkg.sv
// Shared types and geometry helpers for the set-associative instruction cache.
package i_cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [1:0] INST_SIZE_WORD = 2'b10;

  function automatic int unsigned tag_width(input int unsigned a_width,
                                            input int unsigned c_index,
                                            input int unsigned c_offset);
    return a_width - c_index - c_offset - 2;
  endfunction

  function automatic int unsigned num_sets(input int unsigned c_index);
    return 1 << c_index;
  endfunction

  function automatic int unsigned line_words(input int unsigned c_offset);
    return 1 << c_offset;
  endfunction

endpackage

// File: rtl/i_cache_way.sv
// One way of the instruction cache: valid bits, tag array and line data array.
module i_cache_way
  import i_cache_pkg::*;
#(
  parameter int unsigned T_WIDTH  = 23,
  parameter int unsigned C_INDEX  = 7,
  parameter int unsigned C_OFFSET = 2,
  parameter int unsigned W_WIDTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [C_INDEX-1:0] rd_index,
  input  logic [W_WIDTH-1:0] rd_word,
  output logic               rd_valid,
  output logic [T_WIDTH-1:0] rd_tag,
  output logic [31:0]        rd_data,
  input  logic [C_INDEX-1:0] wr_index,
  input  logic [W_WIDTH-1:0] wr_word,
  input  logic               word_we,
  input  logic [31:0]        wr_data,
  input  logic               set_we,
  input  logic [T_WIDTH-1:0] set_tag,
  input  logic               clr_we,
  input  logic               clr_all
);

  localparam int unsigned SETS  = num_sets(C_INDEX);
  localparam int unsigned WORDS = line_words(C_OFFSET);

  logic [SETS-1:0]    valid_q;
  logic [T_WIDTH-1:0] tag_q  [SETS];
  logic [31:0]        data_q [SETS*WORDS];

  logic [C_INDEX+C_OFFSET-1:0] rd_addr;
  logic [C_INDEX+C_OFFSET-1:0] wr_addr;

  if (C_OFFSET > 0) begin : g_words
    assign rd_addr = {rd_index, rd_word};
    assign wr_addr = {wr_index, wr_word};
  end else begin : g_single
    logic unused_word;
    assign unused_word = rd_word[0] ^ wr_word[0];
    assign rd_addr     = rd_index;
    assign wr_addr     = wr_index;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else begin
      if (set_we) valid_q[wr_index] <= 1'b1;
      if (clr_we) valid_q[wr_index] <= 1'b0;
    end
  end

  // Tag and data storage carry no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (set_we)  tag_q[wr_index]  <= set_tag;
    if (word_we) data_q[wr_addr]  <= wr_data;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_addr];

endmodule

// File: rtl/i_cache_sa.sv
// Set-associative instruction cache with burst line refill over a single-word
// req/addr_ok/data_ok bus, LRU replacement, flush squash and invalidate-all.
module i_cache_sa
  import i_cache_pkg::*;
#(
  parameter int unsigned A_WIDTH  = 32,
  parameter int unsigned C_INDEX  = 7,
  parameter int unsigned C_OFFSET = 2,
  parameter int unsigned C_WAYS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic [A_WIDTH-1:0] inst_paddr,
  input  logic               flush,
  input  logic               inv_all,
  output logic [31:0]        instrF,
  output logic               i_data_ok,
  output logic               busy,
  output logic               inst_req,
  output logic               inst_wr,
  output logic [1:0]         inst_size,
  output logic [A_WIDTH-1:0] inst_addr,
  output logic [31:0]        inst_wdata,
  input  logic [31:0]        inst_rdata,
  input  logic               inst_addr_ok,
  input  logic               inst_data_ok
);

  localparam int unsigned T_WIDTH = tag_width(A_WIDTH, C_INDEX, C_OFFSET);
  localparam int unsigned SETS    = num_sets(C_INDEX);
  localparam int unsigned W_WIDTH = (C_OFFSET > 0) ? C_OFFSET : 1;
  localparam int unsigned LO      = C_OFFSET + 2;
  localparam logic [W_WIDTH-1:0] LAST_WORD = W_WIDTH'(line_words(C_OFFSET) - 1);
  localparam logic [A_WIDTH-1:0] OFF_MASK  = (A_WIDTH'(1) << LO) - A_WIDTH'(1);

  state_e             state_q;
  logic [W_WIDTH-1:0] cnt_q;
  logic [A_WIDTH-1:0] base_q;
  logic [C_INDEX-1:0] idx_q;
  logic               victim_q;
  logic               drop_q;
  logic               inv_pend_q;

  logic [T_WIDTH-1:0] cur_tag;
  logic [C_INDEX-1:0] cur_index;
  logic [W_WIDTH-1:0] cur_word;
  logic               unused_lsb;

  assign cur_tag    = inst_paddr[A_WIDTH-1:LO+C_INDEX];
  assign cur_index  = inst_paddr[LO+C_INDEX-1:LO];
  assign unused_lsb = ^inst_paddr[1:0];

  if (C_OFFSET > 0) begin : g_word
    assign cur_word = inst_paddr[C_OFFSET+1:2];
  end else begin : g_no_word
    assign cur_word = '0;
  end

  logic [C_WAYS-1:0]  way_valid;
  logic [C_WAYS-1:0]  hit_vec;
  logic [C_WAYS-1:0]  word_we;
  logic [C_WAYS-1:0]  set_we;
  logic [C_WAYS-1:0]  clr_we;
  logic [T_WIDTH-1:0] way_tag  [C_WAYS];
  logic [31:0]        way_data [C_WAYS];
  logic [C_INDEX-1:0] way_index;

  logic        lookup, hit, hit_ok, start, kill, last;
  logic        refill_wr, install, to_idle, clr_all;
  logic        victim, hit_way;
  logic [31:0] hit_data;

  for (genvar w = 0; w < C_WAYS; w++) begin : g_way
    localparam logic WAY_ID = 1'(w);

    i_cache_way #(
      .T_WIDTH (T_WIDTH),
      .C_INDEX (C_INDEX),
      .C_OFFSET(C_OFFSET),
      .W_WIDTH (W_WIDTH)
    ) u_way (
      .clk     (clk),
      .rst     (rst),
      .rd_index(cur_index),
      .rd_word (cur_word),
      .rd_valid(way_valid[w]),
      .rd_tag  (way_tag[w]),
      .rd_data (way_data[w]),
      .wr_index(way_index),
      .wr_word (cnt_q),
      .word_we (word_we[w]),
      .wr_data (inst_rdata),
      .set_we  (set_we[w]),
      .set_tag (base_q[A_WIDTH-1:LO+C_INDEX]),
      .clr_we  (clr_we[w]),
      .clr_all (clr_all)
    );

    assign hit_vec[w] = way_valid[w] && (way_tag[w] == cur_tag);
    assign word_we[w] = refill_wr && (victim_q == WAY_ID);
    assign set_we[w]  = install && (victim_q == WAY_ID);
    // Victim line goes invalid as the refill starts so a partial line never hits.
    assign clr_we[w]  = start && (victim == WAY_ID);
  end

  always_comb begin
    hit_data = '0;
    hit_way  = 1'b0;
    for (int w = 0; w < C_WAYS; w++) begin
      if (hit_vec[w]) begin
        hit_data = way_data[w];
        hit_way  = 1'(w);
      end
    end
  end

  assign lookup    = (state_q == IDLE) && cpu_req;
  assign hit       = |hit_vec;
  assign hit_ok    = lookup && hit;
  assign start     = lookup && !hit && !flush;
  assign kill      = flush || inv_all;
  assign last      = (cnt_q == LAST_WORD);
  assign refill_wr = (state_q == WAIT) && inst_data_ok && !drop_q && !kill;
  assign install   = refill_wr && last;
  assign to_idle   = ((state_q == REQ) && kill && !inst_addr_ok) ||
                     ((state_q == WAIT) && inst_data_ok && (drop_q || kill || last));
  // A deferred invalidate lands on the same edge the FSM returns to IDLE.
  assign clr_all   = (state_q == IDLE) ? inv_all : (to_idle && (inv_pend_q || inv_all));
  assign way_index = (state_q == IDLE) ? cur_index : idx_q;

  if (C_WAYS == 2) begin : g_lru
    // lru_q[set] names the least recently used way of that set.
    logic [SETS-1:0] lru_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lru_q <= '0;
      end else if (install) begin
        lru_q[idx_q] <= ~victim_q;
      end else if (hit_ok) begin
        lru_q[cur_index] <= ~hit_way;
      end
    end

    always_comb begin
      if (!way_valid[0]) begin
        victim = 1'b0;
      end else if (!way_valid[1]) begin
        victim = 1'b1;
      end else begin
        victim = lru_q[cur_index];
      end
    end
  end else begin : g_direct
    logic unused_lru;
    assign unused_lru = hit_way;
    assign victim     = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      victim_q   <= 1'b0;
      drop_q     <= 1'b0;
      inv_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= REQ;
            base_q   <= inst_paddr & ~OFF_MASK;
            idx_q    <= cur_index;
            victim_q <= victim;
            cnt_q    <= '0;
          end
        end
        REQ: begin
          if (inst_addr_ok) begin
            state_q <= WAIT;
            if (kill)    drop_q     <= 1'b1;
            if (inv_all) inv_pend_q <= 1'b1;
          end else if (kill) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        WAIT: begin
          if (kill)    drop_q     <= 1'b1;
          if (inv_all) inv_pend_q <= 1'b1;
          if (inst_data_ok) begin
            if (drop_q || kill || last) begin
              state_q    <= IDLE;
              cnt_q      <= '0;
              drop_q     <= 1'b0;
              inv_pend_q <= 1'b0;
            end else begin
              state_q <= REQ;
              cnt_q   <= cnt_q + W_WIDTH'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_data_ok  = hit_ok;
  assign instrF     = (hit_ok && !flush) ? hit_data : '0;
  assign busy       = (state_q != IDLE);
  assign inst_req   = (state_q == REQ);
  assign inst_addr  = base_q + (A_WIDTH'(cnt_q) << 2);
  assign inst_wr    = 1'b0;
  assign inst_size  = INST_SIZE_WORD;
  assign inst_wdata = '0;

endmodule
